// File: rtl/int_req_ctrl_if.sv
// int_req_ctrl_if: bundles the interrupt lines, configuration, CPU handshake
// and status outputs of the interrupt request front-end.
// The slave view is taken by int_req_ctrl; the master view belongs to whoever
// drives the raw lines and plays the CPU side of the handshake.
interface int_req_ctrl_if #(
    parameter int N_REQ = 4
);

    // Raw interrupt lines and per-source configuration
    logic [N_REQ-1:0] irq_in;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] edge_mode;

    // CPU handshake strobes
    logic             int_ack;
    logic             int_eoi;
    logic             ovf_clr;

    // Request towards the CPU and status readback
    logic             int_out;
    logic [N_REQ-1:0] int_vec;
    logic             in_service;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] ovf;

    modport master (
        output irq_in,
        output mask,
        output edge_mode,
        output int_ack,
        output int_eoi,
        output ovf_clr,
        input  int_out,
        input  int_vec,
        input  in_service,
        input  pending,
        input  ovf
    );

    modport slave (
        input  irq_in,
        input  mask,
        input  edge_mode,
        input  int_ack,
        input  int_eoi,
        input  ovf_clr,
        output int_out,
        output int_vec,
        output in_service,
        output pending,
        output ovf
    );

endinterface

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: interrupt request front-end feeding the 4-input priority
// encoder. Synchronises the raw lines, captures edge/level requests, masks
// them, picks the highest-priority one as a one-hot vector and runs the
// request / acknowledge / end-of-interrupt handshake with the CPU so that
// only one interrupt is ever in service.
module int_req_ctrl #(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    int_req_ctrl_if.slave   bus
);

    // Handshake states; encoded as plain constants so older tools and
    // netlist viewers see stable literal values.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    // Synchroniser chain: element 0 samples irq_in, the last element is the
    // usable synchronised level.
    logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
    logic [N_REQ-1:0]                  sPrev_q;

    logic [N_REQ-1:0] sLevel;
    logic [N_REQ-1:0] rise;

    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] ovf_q;
    logic [N_REQ-1:0] ovf_d;
    logic [N_REQ-1:0] ovfSet;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             intOut_q;
    logic             intOut_d;
    logic [N_REQ-1:0] intVec_q;
    logic [N_REQ-1:0] intVec_d;
    logic             inService_q;
    logic             inService_d;

    logic             ackTake;
    logic             eoiTake;
    logic [N_REQ-1:0] ackClr;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] sel;

    assign sLevel = sync_q[SYNC_STAGES-1];
    assign rise   = sLevel & ~sPrev_q;

    // Ack only counts while a request is outstanding, eoi only while one is
    // in service; strobes arriving in any other state are dropped here.
    assign ackTake = (state_q == REQ) && bus.int_ack;
    assign eoiTake = (state_q == SERVICE) && bus.int_eoi;
    assign ackClr  = ackTake ? intVec_q : '0;

    assign req = pending_q & ~bus.mask;

    // Shift the raw lines through the synchroniser and remember the last
    // synchronised level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sPrev_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
            sPrev_q <= sLevel;
        end
    end

    // Pending capture: edge sources latch a rise and are cleared by their own
    // ack (a rise in the same cycle wins); level sources simply follow the
    // synchronised line and ignore ack.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.edge_mode[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~ackClr[i]);
            end else begin
                pending_d[i] = sLevel[i];
            end
        end
    end

    // Lost-edge detection: a new rise on a source that is still pending and
    // not being acknowledged this cycle. A new overflow beats ovf_clr.
    always_comb begin
        ovfSet = rise & pending_q & ~ackClr;
        ovf_d  = ovfSet | (bus.ovf_clr ? '0 : ovf_q);
    end

    // Fixed priority: bit 0 highest. Walking downwards lets the lowest set
    // bit overwrite any higher one, leaving a single one-hot bit.
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    // Handshake FSM: latch one request, hold it stable through REQ and
    // SERVICE, and only look at new requests again once back in IDLE.
    always_comb begin
        state_d     = state_q;
        intOut_d    = intOut_q;
        intVec_d    = intVec_q;
        inService_d = inService_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    intVec_d = sel;
                    intOut_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    intVec_d = '0;
                end
            end
            REQ: begin
                if (ackTake) begin
                    intOut_d    = 1'b0;
                    inService_d = 1'b1;
                    state_d     = SERVICE;
                end
            end
            SERVICE: begin
                if (eoiTake) begin
                    inService_d = 1'b0;
                    intVec_d    = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                intOut_d    = 1'b0;
                intVec_d    = '0;
                inService_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Request/status registers; reset silently abandons any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            ovf_q       <= '0;
            state_q     <= IDLE;
            intOut_q    <= 1'b0;
            intVec_q    <= '0;
            inService_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            intOut_q    <= intOut_d;
            intVec_q    <= intVec_d;
            inService_q <= inService_d;
        end
    end

    assign bus.int_out    = intOut_q;
    assign bus.int_vec    = intVec_q;
    assign bus.in_service = inService_q;
    assign bus.pending    = pending_q;
    assign bus.ovf        = ovf_q;

endmodule
